// File: rtl/relm_custom_sched_if.sv
// Request, micro-op issue and completion bus of the custom float/div scheduler.
//   slave  : scheduler side (consumes requests and the datapath result, drives grant/micro-op/completion)
//   master : requester/datapath side (drives requests and the datapath result)
interface relm_custom_sched_if #(
    parameter int unsigned WD = 32
);
    logic          req0_in;
    logic          req1_in;
    logic [2:0]    req0_op_in;
    logic [2:0]    req1_op_in;
    logic [WD-1:0] req0_a_in;
    logic [WD-1:0] req0_x_in;
    logic [WD-1:0] req1_a_in;
    logic [WD-1:0] req1_x_in;
    logic [1:0]    grant_out;
    logic [2:0]    dp_op_out;
    logic          dp_opb_out;
    logic [5:0]    dp_step_out;
    logic [WD-1:0] dp_a_out;
    logic [WD-1:0] dp_x_out;
    logic [WD-1:0] dp_a_in;
    logic [1:0]    done_out;
    logic          err_out;
    logic [WD-1:0] result_out;
    logic          busy_out;

    modport slave (
        input  req0_in, req1_in, req0_op_in, req1_op_in,
        input  req0_a_in, req0_x_in, req1_a_in, req1_x_in, dp_a_in,
        output grant_out, dp_op_out, dp_opb_out, dp_step_out, dp_a_out, dp_x_out,
        output done_out, err_out, result_out, busy_out
    );

    modport master (
        output req0_in, req1_in, req0_op_in, req1_op_in,
        output req0_a_in, req0_x_in, req1_a_in, req1_x_in, dp_a_in,
        input  grant_out, dp_op_out, dp_opb_out, dp_step_out, dp_a_out, dp_x_out,
        input  done_out, err_out, result_out, busy_out
    );
endinterface

// File: rtl/relm_custom_sched.sv
// Two-requester round-robin scheduler that sequences multi-step micro-ops
// through an external combinational float/div datapath.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : relm_custom_sched_if.slave (requests, micro-op issue, completion)
module relm_custom_sched #(
    parameter int unsigned WD  = 32,
    parameter int unsigned WOP = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    relm_custom_sched_if.slave   bus
);
    localparam int unsigned KW      = 6;
    localparam logic [2:0]  OP_RSVD = 3'd7;
    // opb is only issued when its field position clears the 3-bit opcode
    localparam logic        OPB_EN  = (WOP >= 3);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_grant;
    logic [1:0]    r_done;
    logic          r_last;
    logic          r_err;
    logic          r_busy;
    logic [WD-1:0] r_result;
    logic [WD-1:0] r_a;
    logic [WD-1:0] r_x;
    logic [2:0]    r_op;
    logic          r_opb;
    logic [KW-1:0] r_step;

    logic          w_accept;
    logic          w_sel1;
    logic [2:0]    w_op_sel;
    logic [WD-1:0] w_a_sel;
    logic [WD-1:0] w_x_sel;
    logic          w_owner_req;
    logic          w_final;

    // Index of the last step (N-1) of each op's sequence
    function automatic logic [KW-1:0] last_step(input logic [2:0] op);
        case (op)
            3'd0, 3'd1, 3'd3: last_step = KW'(1);
            3'd2:             last_step = KW'(2);
            3'd5, 3'd6:       last_step = KW'(33);
            default:          last_step = KW'(0);
        endcase
    endfunction

    // Round-robin: r_last=1 means requester 1 was granted last, so 0 wins a tie
    assign w_sel1      = bus.req1_in && (!bus.req0_in || !r_last);
    assign w_accept    = (r_state == ST_IDLE) && (bus.req0_in || bus.req1_in);
    assign w_op_sel    = w_sel1 ? bus.req1_op_in : bus.req0_op_in;
    assign w_a_sel     = w_sel1 ? bus.req1_a_in  : bus.req0_a_in;
    assign w_x_sel     = w_sel1 ? bus.req1_x_in  : bus.req0_x_in;
    assign w_owner_req = r_grant[1] ? bus.req1_in : bus.req0_in;
    assign w_final     = (r_step == last_step(r_op));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = (w_op_sel == OP_RSVD) ? ST_DONE : ST_RUN;
            ST_RUN: begin
                if (!w_owner_req)  w_state_nxt = ST_IDLE;
                else if (w_final)  w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant, micro-op issue and completion registers; issue regs are zero outside RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant  <= '0;
            r_done   <= '0;
            r_last   <= 1'b1;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_result <= '0;
            r_a      <= '0;
            r_x      <= '0;
            r_op     <= '0;
            r_opb    <= 1'b0;
            r_step   <= '0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    r_done <= '0;
                    if (w_accept) begin
                        r_grant <= w_sel1 ? 2'b10 : 2'b01;
                        r_last  <= w_sel1;
                        if (w_op_sel == OP_RSVD) begin
                            r_err    <= 1'b1;
                            r_result <= '0;
                            r_done   <= w_sel1 ? 2'b10 : 2'b01;
                        end else begin
                            r_op   <= w_op_sel;
                            r_opb  <= 1'b0;
                            r_step <= '0;
                            r_a    <= w_a_sel;
                            r_x    <= w_x_sel;
                        end
                    end
                end
                ST_RUN: begin
                    if (!w_owner_req || w_final) begin
                        r_op   <= '0;
                        r_opb  <= 1'b0;
                        r_step <= '0;
                        r_a    <= '0;
                        r_x    <= '0;
                        if (!w_owner_req) begin
                            r_grant <= '0;
                        end else begin
                            r_result <= bus.dp_a_in;
                            r_err    <= 1'b0;
                            r_done   <= r_grant;
                        end
                    end else begin
                        r_a    <= bus.dp_a_in;
                        r_step <= r_step + KW'(1);
                        r_opb  <= OPB_EN;
                    end
                end
                ST_DONE: begin
                    r_done  <= '0;
                    r_grant <= '0;
                end
                default: begin
                    r_done  <= '0;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign bus.grant_out   = r_grant;
    assign bus.dp_op_out   = r_op;
    assign bus.dp_opb_out  = r_opb;
    assign bus.dp_step_out = r_step;
    assign bus.dp_a_out    = r_a;
    assign bus.dp_x_out    = r_x;
    assign bus.done_out    = r_done;
    assign bus.err_out     = r_err;
    assign bus.result_out  = r_result;
    assign bus.busy_out    = r_busy;
endmodule

// File: tb/tb_relm_custom_sched.sv
// Directed bench for relm_custom_sched with a completion scoreboard.
module tb_relm_custom_sched;
    logic clk;
    logic rst_n;

    relm_custom_sched_if #(.WD(32)) bus ();

    relm_custom_sched #(.WD(32), .WOP(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: mixes operand, step and opb so every issued field matters
    assign bus.dp_a_in = bus.dp_a_out + bus.dp_x_out + 32'(bus.dp_step_out)
                       + (bus.dp_opb_out ? 32'h100 : 32'h0);

    typedef struct {
        logic [1:0]  done;
        logic        err;
        logic [31:0] res;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int n_cmp = 0;
    int n_bad = 0;

    function automatic int seq_len(input logic [2:0] op);
        case (op)
            3'd0: return 2;
            3'd1: return 2;
            3'd2: return 3;
            3'd3: return 2;
            3'd4: return 1;
            3'd5: return 34;
            3'd6: return 34;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] x, input int n);
        logic [31:0] acc;
        acc = a;
        for (int k = 0; k < n; k++)
            acc = acc + x + 32'(k) + ((k != 0) ? 32'h100 : 32'h0);
        return acc;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] d, input logic e, input logic [31:0] r);
        exp_t t;
        t.done = d;
        t.err  = e;
        t.res  = r;
        q.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int c;
        c = 0;
        while (bus.done_out == 2'b00 && c < max_cyc) begin
            tick();
            c++;
        end
        check({tag, "_timeout"}, 64'(bus.done_out != 2'b00), 64'd1);
    endtask

    // Completion monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && bus.done_out != 2'b00) begin
            if (q.size() == 0) begin
                check("unexpected_done", 64'(bus.done_out), 64'd0);
            end else begin
                m_e = q.pop_front();
                check("sb_done",   64'(bus.done_out),   64'(m_e.done));
                check("sb_err",    64'(bus.err_out),    64'(m_e.err));
                check("sb_result", 64'(bus.result_out), 64'(m_e.res));
            end
        end
    end

    initial begin
        int guard;
        bus.req0_in = 1'b0;  bus.req1_in = 1'b0;
        bus.req0_op_in = '0; bus.req1_op_in = '0;
        bus.req0_a_in = '0;  bus.req0_x_in = '0;
        bus.req1_a_in = '0;  bus.req1_x_in = '0;
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant",  64'(bus.grant_out),   64'd0);
        check("rst_busy",   64'(bus.busy_out),    64'd0);
        check("rst_done",   64'(bus.done_out),    64'd0);
        check("rst_err",    64'(bus.err_out),     64'd0);
        check("rst_result", 64'(bus.result_out),  64'd0);
        check("rst_step",   64'(bus.dp_step_out), 64'd0);
        check("rst_dpa",    64'(bus.dp_a_out),    64'd0);
        rst_n = 1'b1;

        // FMUL from requester 0, operands changed after accept
        bus.req0_in = 1'b1; bus.req0_op_in = 3'd1;
        bus.req0_a_in = 32'h3F800000; bus.req0_x_in = 32'h40000000;
        push(2'b01, 1'b0, model(32'h3F800000, 32'h40000000, seq_len(3'd1)));
        tick();
        check("fmul_grant0", 64'(bus.grant_out),   64'd1);
        check("fmul_busy",   64'(bus.busy_out),    64'd1);
        check("fmul_op",     64'(bus.dp_op_out),   64'd1);
        check("fmul_step0",  64'(bus.dp_step_out), 64'd0);
        check("fmul_opb0",   64'(bus.dp_opb_out),  64'd0);
        check("fmul_a0",     64'(bus.dp_a_out),    64'h3F800000);
        check("fmul_x0",     64'(bus.dp_x_out),    64'h40000000);
        bus.req0_a_in = 32'hDEAD; bus.req0_x_in = 32'hBEEF; bus.req0_op_in = 3'd7;
        tick();
        check("fmul_step1",  64'(bus.dp_step_out), 64'd1);
        check("fmul_opb1",   64'(bus.dp_opb_out),  64'd1);
        check("fmul_a1",     64'(bus.dp_a_out),    64'h7F800000);
        check("fmul_x1",     64'(bus.dp_x_out),    64'h40000000);
        check("fmul_op1",    64'(bus.dp_op_out),   64'd1);
        tick();
        check("fmul_done",   64'(bus.done_out),    64'd1);
        check("fmul_grantd", 64'(bus.grant_out),   64'd1);
        check("fmul_dpidle", 64'(bus.dp_a_out),    64'd0);
        bus.req0_in = 1'b0;
        tick();
        check("fmul_idle_busy",  64'(bus.busy_out),  64'd0);
        check("fmul_idle_grant", 64'(bus.grant_out), 64'd0);
        check("fmul_idle_done",  64'(bus.done_out),  64'd0);

        // Tie from reset: 0 first, then 1, then 0 again
        rst_n = 1'b0; #2; rst_n = 1'b1;
        bus.req0_in = 1'b1; bus.req0_op_in = 3'd4; bus.req0_a_in = 32'h11;   bus.req0_x_in = 32'h22;
        bus.req1_in = 1'b1; bus.req1_op_in = 3'd4; bus.req1_a_in = 32'h1000; bus.req1_x_in = 32'h2000;
        push(2'b01, 1'b0, model(32'h11,   32'h22,   1));
        push(2'b10, 1'b0, model(32'h1000, 32'h2000, 1));
        push(2'b01, 1'b0, model(32'h5,    32'h7,    1));
        tick();
        check("rr_grant_first", 64'(bus.grant_out), 64'd1);
        wait_done("rr_first", 8);
        bus.req0_in = 1'b0;
        tick();
        check("rr_idle_grant", 64'(bus.grant_out), 64'd0);
        bus.req0_in = 1'b1; bus.req0_a_in = 32'h5; bus.req0_x_in = 32'h7;
        tick();
        check("rr_grant_second", 64'(bus.grant_out), 64'd2);
        wait_done("rr_second", 8);
        bus.req1_in = 1'b0;
        tick();
        tick();
        check("rr_grant_third", 64'(bus.grant_out), 64'd1);
        wait_done("rr_third", 8);
        bus.req0_in = 1'b0;
        tick();

        // DIV from requester 1: 34 steps
        bus.req1_in = 1'b1; bus.req1_op_in = 3'd5; bus.req1_a_in = 32'h100; bus.req1_x_in = 32'h3;
        push(2'b10, 1'b0, model(32'h100, 32'h3, seq_len(3'd5)));
        tick();
        for (int k = 0; k < 34; k++) begin
            check($sformatf("div_step%0d", k), 64'(bus.dp_step_out), 64'(k));
            check($sformatf("div_opb%0d", k),  64'(bus.dp_opb_out),  64'(k != 0));
            tick();
        end
        check("div_done",  64'(bus.done_out), 64'd2);
        check("div_stepz", 64'(bus.dp_step_out), 64'd0);
        bus.req1_in = 1'b0;
        tick();
        check("div_idle_busy", 64'(bus.busy_out), 64'd0);

        // Reserved op: immediate error completion
        bus.req0_in = 1'b1; bus.req0_op_in = 3'd7; bus.req0_a_in = 32'hABC;
        push(2'b01, 1'b1, 32'h0);
        tick();
        check("rsvd_done",   64'(bus.done_out),    64'd1);
        check("rsvd_err",    64'(bus.err_out),     64'd1);
        check("rsvd_result", 64'(bus.result_out),  64'd0);
        check("rsvd_dpop",   64'(bus.dp_op_out),   64'd0);
        check("rsvd_dpa",    64'(bus.dp_a_out),    64'd0);
        check("rsvd_busy",   64'(bus.busy_out),    64'd1);
        bus.req0_in = 1'b0;
        tick();
        check("rsvd_idle_busy", 64'(bus.busy_out), 64'd0);
        check("rsvd_err_hold",  64'(bus.err_out),  64'd1);

        // ROUND then aborted FDIV: result and err must hold
        bus.req1_in = 1'b1; bus.req1_op_in = 3'd3; bus.req1_a_in = 32'h40; bus.req1_x_in = 32'h2;
        push(2'b10, 1'b0, 32'h145);
        tick();
        wait_done("round", 8);
        bus.req1_in = 1'b0;
        tick();
        bus.req1_in = 1'b1; bus.req1_op_in = 3'd6; bus.req1_a_in = 32'h1; bus.req1_x_in = 32'h1;
        tick();
        guard = 0;
        while (bus.dp_step_out != 6'd10 && guard < 40) begin
            tick();
            guard++;
        end
        check("abort_reach10", 64'(bus.dp_step_out), 64'd10);
        bus.req1_in = 1'b0;
        tick();
        check("abort_grant",  64'(bus.grant_out),   64'd0);
        check("abort_busy",   64'(bus.busy_out),    64'd0);
        check("abort_step",   64'(bus.dp_step_out), 64'd0);
        check("abort_result", 64'(bus.result_out),  64'h145);
        check("abort_err",    64'(bus.err_out),     64'd0);
        repeat (5) tick();
        check("abort_nodone", 64'(bus.done_out), 64'd0);

        // Asynchronous reset mid-FADD
        bus.req0_in = 1'b1; bus.req0_op_in = 3'd2; bus.req0_a_in = 32'h7; bus.req0_x_in = 32'h9;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_grant",  64'(bus.grant_out),   64'd0);
        check("arst_busy",   64'(bus.busy_out),    64'd0);
        check("arst_step",   64'(bus.dp_step_out), 64'd0);
        check("arst_dpa",    64'(bus.dp_a_out),    64'd0);
        check("arst_result", 64'(bus.result_out),  64'd0);
        check("arst_done",   64'(bus.done_out),    64'd0);
        bus.req0_in = 1'b0;
        #1;
        rst_n = 1'b1;
        repeat (4) tick();
        check("arst_post_busy", 64'(bus.busy_out), 64'd0);

        // First accept after reset release
        bus.req1_in = 1'b1; bus.req1_op_in = 3'd0; bus.req1_a_in = 32'h10; bus.req1_x_in = 32'h20;
        push(2'b10, 1'b0, 32'h151);
        tick();
        check("post_rst_grant", 64'(bus.grant_out), 64'd2);
        wait_done("post_rst", 8);
        bus.req1_in = 1'b0;
        repeat (2) tick();

        check("sb_empty", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
